// File: rtl/dehaze_pkg.sv
// Shared constants and types for the dehaze pipeline stages.
package dehaze_pkg;

    // Fixed-point widths used across the pipeline.
    localparam int Q16_W = 16;
    localparam int PIX_W = 8;

    // Haze-retention factor omega = 0.9 in Q0.16.
    localparam logic [Q16_W-1:0] OMEGA_Q16 = 16'd58982;

    // Reciprocal substituted when the atmospheric light is zero.
    localparam logic [Q16_W-1:0] SAT_Q16 = 16'hFFFF;

    // Sequencer states of the atmospheric-light inverter.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DIV    = 3'd2,
        ST_STORE  = 3'd3,
        ST_COMMIT = 3'd4
    } inv_state_t;

endpackage

// File: rtl/seq_div_16by8.sv
// Restoring divider: 16-bit dividend by 8-bit divisor, one quotient bit per
// cycle, MSB first. A load pulse arms it; it then runs exactly 16 iterations.
// 'finished' is high during the cycle whose closing edge performs the 16th
// iteration, so the quotient is final in the cycle after 'finished'.
module seq_div_16by8
    import dehaze_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Q16_W-1:0] dividend,
    input  logic [PIX_W-1:0] divisor,
    output logic [Q16_W-1:0] quotient,
    output logic             zero,
    output logic             finished
);

    // 9-bit partial remainder: the shifted value can reach 2*divisor-1,
    // so one extra bit keeps the compare free of overflow.
    logic [PIX_W:0]   rem_q;
    logic [Q16_W-1:0] quo_q;
    logic [PIX_W-1:0] dvs_q;
    logic [3:0]       cnt_q;
    logic             active_q;
    logic             zero_q;
    logic             sub_ok;

    // Trial compare of the shifted remainder against the divisor.
    always_comb begin
        sub_ok = ({rem_q, quo_q[Q16_W-1]} >= {2'b00, dvs_q});
    end

    // Iteration register: load arms, then shift/subtract for 16 cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            zero_q   <= 1'b0;
        end else if (load) begin
            rem_q    <= '0;
            quo_q    <= dividend;
            dvs_q    <= divisor;
            cnt_q    <= '0;
            active_q <= 1'b1;
            zero_q   <= (divisor == '0);
        end else if (active_q) begin
            if (sub_ok) begin
                rem_q <= 9'({rem_q, quo_q[Q16_W-1]} - {2'b00, dvs_q});
            end else begin
                rem_q <= {rem_q[PIX_W-1:0], quo_q[Q16_W-1]};
            end
            quo_q <= {quo_q[Q16_W-2:0], sub_ok};
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                active_q <= 1'b0;
            end
        end
    end

    assign quotient = quo_q;
    assign zero     = zero_q;
    assign finished = active_q && (cnt_q == 4'd15);

endmodule

// File: rtl/atm_light_inverter.sv
// Per-frame reciprocal of the atmospheric light: Ac_Inv = omega / Ac (Q0.16)
// for R, G and B in turn through one shared divider. The three outputs are
// replaced together on a single edge so downstream never mixes two frames.
//
// Handshake: start is a one-cycle request honoured only in IDLE; Ac_R/G/B are
// captured on that edge. busy is high while the channels are being computed;
// done pulses for one cycle (COMMIT) and the outputs are already new in that
// cycle. Requests while busy or during done are dropped, not queued.
module atm_light_inverter
    import dehaze_pkg::*;
#(
    parameter logic [Q16_W-1:0] OMEGA     = OMEGA_Q16,
    parameter logic [Q16_W-1:0] SAT_VALUE = SAT_Q16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] Ac_R,
    input  logic [PIX_W-1:0] Ac_G,
    input  logic [PIX_W-1:0] Ac_B,
    output logic             busy,
    output logic             done,
    output logic [Q16_W-1:0] Ac_Inv_R,
    output logic [Q16_W-1:0] Ac_Inv_G,
    output logic [Q16_W-1:0] Ac_Inv_B
);

    // Sequencer state, visible hierarchically for checkers.
    inv_state_t       state;
    inv_state_t       state_next;

    logic [1:0]       channel;
    logic [PIX_W-1:0] ac_r_q;
    logic [PIX_W-1:0] ac_g_q;
    logic [PIX_W-1:0] ac_b_q;
    logic [PIX_W-1:0] divisor;
    logic [Q16_W-1:0] shadow_r;
    logic [Q16_W-1:0] shadow_g;
    logic [Q16_W-1:0] div_quotient;
    logic [Q16_W-1:0] result;
    logic             div_load;
    logic             div_zero;
    logic             div_finished;

    // Select the captured channel that feeds the divider.
    always_comb begin
        divisor = ac_b_q;
        case (channel)
            2'd0:    divisor = ac_r_q;
            2'd1:    divisor = ac_g_q;
            default: divisor = ac_b_q;
        endcase
    end

    assign div_load = (state == ST_LOAD);
    assign result   = div_zero ? SAT_VALUE : div_quotient;

    seq_div_16by8 u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .dividend (OMEGA),
        .divisor  (divisor),
        .quotient (div_quotient),
        .zero     (div_zero),
        .finished (div_finished)
    );

    // Next-state logic for the channel sequencer.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_LOAD;
            ST_LOAD:   state_next = ST_DIV;
            ST_DIV:    if (div_finished) state_next = ST_STORE;
            ST_STORE:  state_next = (channel == 2'd2) ? ST_COMMIT : ST_LOAD;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture, per-channel shadow storage and the atomic output update.
    // The blue result is the last one produced, so it goes straight to the
    // output alongside the red and green shadows on the edge entering COMMIT;
    // that way the outputs are already new in the cycle done is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            channel  <= '0;
            ac_r_q   <= '0;
            ac_g_q   <= '0;
            ac_b_q   <= '0;
            shadow_r <= '0;
            shadow_g <= '0;
            Ac_Inv_R <= '0;
            Ac_Inv_G <= '0;
            Ac_Inv_B <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ac_r_q  <= Ac_R;
                        ac_g_q  <= Ac_G;
                        ac_b_q  <= Ac_B;
                        channel <= 2'd0;
                    end
                end
                ST_STORE: begin
                    case (channel)
                        2'd0: begin
                            shadow_r <= result;
                            channel  <= 2'd1;
                        end
                        2'd1: begin
                            shadow_g <= result;
                            channel  <= 2'd2;
                        end
                        default: begin
                            Ac_Inv_R <= shadow_r;
                            Ac_Inv_G <= shadow_g;
                            Ac_Inv_B <= result;
                            channel  <= 2'd0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_LOAD) || (state == ST_DIV) || (state == ST_STORE);
    assign done = (state == ST_COMMIT);

endmodule

// File: tb/tb_atm_light_inverter.sv
// Bench for atm_light_inverter: scenario tasks with a queue of expected
// {R,G,B} reciprocals pushed at each start and popped at each done.
module tb_atm_light_inverter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  ac_r = '0;
    logic [7:0]  ac_g = '0;
    logic [7:0]  ac_b = '0;
    logic        busy;
    logic        done;
    logic [15:0] inv_r;
    logic [15:0] inv_g;
    logic [15:0] inv_b;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [47:0] exp_q[$];

    // Clock and free-running cycle count.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    atm_light_inverter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Ac_R     (ac_r),
        .Ac_G     (ac_g),
        .Ac_B     (ac_b),
        .busy     (busy),
        .done     (done),
        .Ac_Inv_R (inv_r),
        .Ac_Inv_G (inv_g),
        .Ac_Inv_B (inv_b)
    );

    // Reference: floor(58982 / ac), zero maps to saturation.
    function automatic logic [15:0] ref_inv(input logic [7:0] ac);
        int q;
        if (ac == 8'd0) return 16'hFFFF;
        q = 58982 / int'(ac);
        return 16'(q);
    endfunction

    // Driver: one-cycle start with the given channels; returns at cycle +1.
    task automatic drive_start(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(negedge clk);
        ac_r  = r;
        ac_g  = g;
        ac_b  = b;
        start = 1'b1;
        exp_q.push_back({ref_inv(r), ref_inv(g), ref_inv(b)});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: walks cycles +1.. until done (bounded), optionally pulsing
    // start with scrambled inputs at cycles p1/p2/p3. Reports the latency
    // (0 on timeout), busy-shape errors and output changes before done.
    task automatic wait_done(input int p1, input int p2, input int p3,
                             output int lat, output int busy_err, output int hold_err);
        logic [47:0] prev;
        prev     = {inv_r, inv_g, inv_b};
        lat      = 0;
        busy_err = 0;
        hold_err = 0;
        for (int n = 1; n <= 120; n++) begin
            if (n > 1) @(negedge clk);
            start = (n == p1) || (n == p2) || (n == p3);
            if (start) begin
                ac_r = 8'($urandom_range(0, 255));
                ac_g = 8'($urandom_range(0, 255));
                ac_b = 8'($urandom_range(0, 255));
            end
            if (done) begin
                lat = n;
                if (busy !== 1'b0) busy_err++;
                break;
            end
            if (busy !== (n <= 54)) busy_err++;
            if ({inv_r, inv_g, inv_b} !== prev) hold_err++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%b done=%b required busy=0 done=0", busy, done);
        end
        total++;
        if ({inv_r, inv_g, inv_b} !== 48'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0", {inv_r, inv_g, inv_b});
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_basic(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input string name);
        int lat, berr, herr;
        logic [47:0] e;
        drive_start(r, g, b);
        wait_done(0, 0, 0, lat, berr, herr);
        e = exp_q.pop_front();
        total++;
        if (lat != 55) begin
            bad++;
            $display("FAIL %s_latency: got %0d required 55", name, lat);
        end
        total++;
        if (berr != 0) begin
            bad++;
            $display("FAIL %s_busy: %0d cycles wrong, required 0", name, berr);
        end
        total++;
        if ({inv_r, inv_g, inv_b} !== e) begin
            bad++;
            $display("FAIL %s_outputs: got %h required %h", name, {inv_r, inv_g, inv_b}, e);
        end
    endtask

    task automatic test_start_ignored();
        int lat, berr, herr, extra;
        logic [47:0] e;
        drive_start(8'd255, 8'd128, 8'd1);
        wait_done(10, 54, 55, lat, berr, herr);
        e = exp_q.pop_front();
        total++;
        if (lat != 55) begin
            bad++;
            $display("FAIL ignore_latency: got %0d required 55", lat);
        end
        total++;
        if ({inv_r, inv_g, inv_b} !== e) begin
            bad++;
            $display("FAIL ignore_outputs: got %h required %h", {inv_r, inv_g, inv_b}, e);
        end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done !== 1'b0 || busy !== 1'b0) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL ignore_single_done: %0d extra busy/done cycles, required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, berr, herr, c1, c2;
        logic [47:0] e;
        drive_start(8'd40, 8'd90, 8'd250);
        wait_done(0, 0, 0, lat1, berr, herr);
        c1 = cyc;
        e = exp_q.pop_front();
        total++;
        if ({inv_r, inv_g, inv_b} !== e) begin
            bad++;
            $display("FAIL b2b_first: got %h required %h", {inv_r, inv_g, inv_b}, e);
        end
        drive_start(8'd3, 8'd0, 8'd77);
        wait_done(0, 0, 0, lat2, berr, herr);
        c2 = cyc;
        e = exp_q.pop_front();
        total++;
        if (lat2 == 0 || lat1 == 0 || (c2 - c1) != 56) begin
            bad++;
            $display("FAIL b2b_gap: got %0d cycles required 56", c2 - c1);
        end
        total++;
        if (herr != 0) begin
            bad++;
            $display("FAIL b2b_hold: outputs changed in %0d cycles before done, required 0", herr);
        end
        total++;
        if ({inv_r, inv_g, inv_b} !== e) begin
            bad++;
            $display("FAIL b2b_second: got %h required %h", {inv_r, inv_g, inv_b}, e);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        logic [47:0] dropped;
        drive_start(8'd10, 8'd20, 8'd30);
        repeat (28) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        dropped = exp_q.pop_back();
        total++;
        if ({inv_r, inv_g, inv_b} !== 48'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_clear: outputs=%h busy=%b required 0/0 (aborted %h)",
                     {inv_r, inv_g, inv_b}, busy, dropped);
        end
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midreset_no_done: %0d busy/done cycles, required 0", seen);
        end
    endtask

    task automatic test_random_sweep();
        int lat, berr, herr;
        logic [7:0] r, g, b;
        logic [47:0] e;
        for (int i = 0; i < 500; i++) begin
            r = 8'($urandom_range(0, 255));
            g = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (i == 0) begin r = 8'd0; g = 8'd1; b = 8'd255; end
            if (i == 1) begin r = 8'd2; g = 8'd0; b = 8'd0; end
            drive_start(r, g, b);
            wait_done(0, 0, 0, lat, berr, herr);
            e = exp_q.pop_front();
            total++;
            if (lat != 55 || berr != 0) begin
                bad++;
                $display("FAIL sweep_timing[%0d]: latency %0d busy_err %0d required 55/0", i, lat, berr);
            end
            total++;
            if ({inv_r, inv_g, inv_b} !== e) begin
                bad++;
                $display("FAIL sweep_outputs[%0d]: Ac=%0d/%0d/%0d got %h required %h",
                         i, r, g, b, {inv_r, inv_g, inv_b}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(8'd255, 8'd128, 8'd1, "basic");
        test_basic(8'd200, 8'd0, 8'd200, "zero_g");
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_basic(8'd255, 8'd128, 8'd1, "after_reset");
        test_random_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
